laser_shot_scheduler: RTL and testbench

- Shares one laser exposure timer among NREQ treatment stations.
- Picks the next requester by round-robin, then sequences it through arm, fire and cooldown phases.
- Drives the single laser enable and returns a per-station completion pulse.
- Sits above the surgery timer/light path: it replaces the single-button control with an arbitrated, length-programmable shot sequence.

---
 rtl/laser_sched_pkg.sv | 14 +
 rtl/laser_shot_scheduler_rr_pick.sv | 31 +++
 rtl/laser_shot_scheduler.sv | 127 ++++++++++++
 tb/tb_laser_shot_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_sched_pkg.sv
// Shared state encoding and default sizing for the laser shot scheduler.
package laser_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    FIRE = 2'b10,
    COOL = 2'b11
  } state_t;

endpackage

// File: rtl/laser_shot_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   win_idx
);

  logic found;
  int   cand;

  // Offsets 1..NREQ visit ptr+1 first and ptr itself last.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        win_idx      = PW'(cand);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/laser_shot_scheduler.sv
// Arbitrates NREQ stations onto one laser: round-robin grant, then ARM -> FIRE -> COOL.
module laser_shot_scheduler
  import laser_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             abort,
  input  logic [NBITS-1:0] fire_len,
  input  logic [NBITS-1:0] cool_len,
  output logic [NREQ-1:0]  grant,
  output logic             light,
  output logic             busy,
  output logic [NREQ-1:0]  done,
  output logic             aborted
);

  localparam int PW = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_d, done_d;
  logic             light_d, busy_d, aborted_d;
  logic [NREQ-1:0]  pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             cut;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  // Emergency stop, or the served station withdrawing its request, ends the shot early.
  assign cut = abort || !(|(req & grant));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant;
    light_d   = 1'b0;
    done_d    = '0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|req) && !abort) begin
          grant_d = pick_onehot;
          ptr_d   = pick_idx;
          state_d = ARM;
        end
      end
      ARM: begin
        if (cut) begin
          state_d   = COOL;
          cnt_d     = cool_len;
          grant_d   = '0;
          aborted_d = 1'b1;
        end else if (fire_len == '0) begin
          state_d = COOL;
          cnt_d   = cool_len;
          grant_d = '0;
          done_d  = grant;
        end else begin
          state_d = FIRE;
          cnt_d   = fire_len;
          light_d = 1'b1;
        end
      end
      FIRE: begin
        if (cut) begin
          state_d   = COOL;
          cnt_d     = cool_len;
          grant_d   = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == NBITS'(1)) begin
          state_d = COOL;
          cnt_d   = cool_len;
          grant_d = '0;
          done_d  = grant;
        end else begin
          cnt_d   = cnt_q - NBITS'(1);
          light_d = 1'b1;
        end
      end
      COOL: begin
        // A cool length of 0 or 1 both give a single COOL cycle.
        if (cnt_q <= NBITS'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - NBITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      grant   <= '0;
      light   <= 1'b0;
      busy    <= 1'b0;
      done    <= '0;
      aborted <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      light   <= light_d;
      busy    <= busy_d;
      done    <= done_d;
      aborted <= aborted_d;
    end
  end

endmodule

// File: tb/tb_laser_shot_scheduler.sv
// Scoreboard bench for laser_shot_scheduler: directed shots, expected events queued up front.
module tb_laser_shot_scheduler;
  import laser_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 32;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;
  localparam int EV_IDLE  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic             abort = 1'b0;
  logic [NBITS-1:0] fire_len = '0;
  logic [NBITS-1:0] cool_len = '0;
  logic [NREQ-1:0]  grant;
  logic             light;
  logic             busy;
  logic [NREQ-1:0]  done;
  logic             aborted;

  laser_shot_scheduler #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .abort    (abort),
    .fire_len (fire_len),
    .cool_len (cool_len),
    .grant    (grant),
    .light    (light),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              kind;
    logic [NREQ-1:0] val;
    int              gap;
    int              nl;
  } ev_t;

  ev_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;

  // kind, value, cycles since grant (DONE/ABORT) or since shot end (IDLE), light cycles
  task automatic expect_ev(input int kind, input logic [NREQ-1:0] val, input int gap, input int nl);
    ev_t e;
    e.kind = kind; e.val = val; e.gap = gap; e.nl = nl;
    exp_q.push_back(e);
  endtask

  task automatic expect_shot(input logic [NREQ-1:0] g, input int f, input int c);
    expect_ev(EV_GRANT, g, 0, 0);
    expect_ev(EV_DONE, g, f + 1, f);
    expect_ev(EV_IDLE, '0, 0, 0);
    exp_q[exp_q.size()-1].gap = (c < 1) ? 1 : c;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    compared++;
    if (act !== req_v) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  task automatic got(input int kind, input logic [NREQ-1:0] val, input int gap, input int nl);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL event: got kind=%0d val=%b gap=%0d light=%0d, required none", kind, val, gap, nl);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.gap != gap || e.nl != nl) begin
        mismatched++;
        $display("FAIL event: got kind=%0d val=%b gap=%0d light=%0d, required kind=%0d val=%b gap=%0d light=%0d",
                 kind, val, gap, nl, e.kind, e.val, e.gap, e.nl);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and invariant checks.
  int cyc = 0, tg = 0, te = 0, nlight = 0;
  logic [NREQ-1:0] pg = '0;
  logic            pb = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      pg = '0;
      pb = 1'b0;
    end else begin
      cyc++;
      if (light) nlight++;
      if (grant != '0 && pg == '0) begin
        tg = cyc;
        nlight = 0;
        got(EV_GRANT, grant, 0, 0);
      end
      if (done != '0) begin
        got(EV_DONE, done, cyc - tg, nlight);
        te = cyc;
      end
      if (aborted) begin
        got(EV_ABORT, '0, cyc - tg, nlight);
        te = cyc;
      end
      if (!busy && pb) got(EV_IDLE, '0, cyc - te, 0);
      check("invariant", {28'd0, $onehot0(grant), (!light || grant != '0),
                          !(done != '0 && aborted), $onehot0(done)}, 32'hF);
      pg = grant;
      pb = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keep requests up until each station's done, then wait for the scheduler to go idle.
  task automatic serve();
    int n;
    n = 0;
    while (!(req == '0 && !busy) && n < 300) begin
      tick();
      req = req & ~done;
      n++;
    end
    if (n >= 300) begin
      mismatched++;
      $display("FAIL serve_timeout: req=%b busy=%b, required idle", req, busy);
    end
  endtask

  task automatic wait_light(input int cycles);
    int n, seen;
    n = 0; seen = 0;
    while (seen < cycles && n < 100) begin
      tick();
      if (light) seen++;
      n++;
    end
    if (seen < cycles) begin
      mismatched++;
      $display("FAIL light_timeout: got %0d light cycles, required %0d", seen, cycles);
    end
  endtask

  initial begin
    int ndone, n;

    // Reset state
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    reset = 1'b1;
    tick();

    // Single shot on station 0
    fire_len = 3; cool_len = 2; req = 4'b0001;
    expect_shot(4'b0001, 3, 2);
    serve();

    // Abort in second FIRE cycle; aborted station keeps requesting but loses its turn
    fire_len = 5; cool_len = 3; req = 4'b0110;
    expect_ev(EV_GRANT, 4'b0010, 0, 0);
    expect_ev(EV_ABORT, '0, 3, 2);
    expect_ev(EV_IDLE, '0, 3, 0);
    expect_shot(4'b0100, 2, 1);
    expect_shot(4'b0010, 2, 1);
    wait_light(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    fire_len = 2; cool_len = 1;
    serve();

    // Zero-length exposure
    fire_len = 0; cool_len = 0; req = 4'b0100;
    expect_shot(4'b0100, 0, 0);
    serve();

    // Served station withdraws mid-FIRE; the others are served afterwards
    fire_len = 5; cool_len = 3; req = 4'b1011;
    expect_ev(EV_GRANT, 4'b1000, 0, 0);
    expect_ev(EV_ABORT, '0, 3, 2);
    expect_ev(EV_IDLE, '0, 3, 0);
    expect_shot(4'b0001, 2, 1);
    expect_shot(4'b0010, 2, 1);
    wait_light(2);
    req[3] = 1'b0;
    tick();
    fire_len = 2; cool_len = 1;
    serve();

    // Asynchronous reset mid-FIRE
    fire_len = 10; cool_len = 2; req = 4'b0001;
    expect_ev(EV_GRANT, 4'b0001, 0, 0);
    wait_light(3);
    #2 reset = 1'b0;
    #1;
    check("areset_light", 32'(light), 32'd0);
    check("areset_grant", 32'(grant), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    req = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    fire_len = 1; cool_len = 1; req = 4'b1001;
    expect_shot(4'b0001, 1, 1);
    expect_shot(4'b1000, 1, 1);
    serve();

    // All stations held: strict rotation from station 0
    fire_len = 1; cool_len = 0; req = 4'b1111;
    expect_shot(4'b0001, 1, 0);
    expect_shot(4'b0010, 1, 0);
    expect_shot(4'b0100, 1, 0);
    expect_shot(4'b1000, 1, 0);
    expect_shot(4'b0001, 1, 0);
    ndone = 0; n = 0;
    while (ndone < 5 && n < 200) begin
      tick();
      if (done != '0) ndone++;
      n++;
    end
    req = '0;
    if (ndone < 5) begin
      mismatched++;
      $display("FAIL rotation_timeout: got %0d done pulses, required 5", ndone);
    end
    serve();

    repeat (4) tick();
    check("events_left", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
